// File: rtl/gpr_wb_arbiter.sv
// Write-back arbiter for the GPR file's single write port: ALU results win, load results
// queue behind them, and a per-register pending scoreboard stalls decode on outstanding loads.
module gpr_wb_arbiter #(
  parameter int LDQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_rrd,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  output logic        stall,
  output logic        gpr_we,
  output logic [4:0]  gpr_rd,
  output logic [31:0] gpr_rrd,
  output logic        waw_err
);

  localparam int PW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int CW = $clog2(LDQ_DEPTH + 1);

  logic [4:0]    q_rd   [LDQ_DEPTH];
  logic [31:0]   q_data [LDQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   pending, pending_next;

  logic alu_act, ld_xfer, ld_keep, q_empty, q_full;
  logic pop, bypass, push;
  logic          port_we;
  logic [4:0]    port_rd;
  logic [31:0]   port_data;

  // Load handshake: data moves on a cycle where ld_valid && ld_ready; the producer holds
  // ld_valid/ld_rd/ld_data stable until then. ld_ready depends on queue state only.
  assign q_empty  = (count == '0);
  assign q_full   = (count == CW'(LDQ_DEPTH));
  assign ld_ready = !q_full;

  assign alu_act = alu_we && (alu_rd != 5'd0);
  assign ld_xfer = ld_valid && ld_ready;
  assign ld_keep = ld_xfer && (ld_rd != 5'd0);   // $0 loads are accepted and dropped
  assign pop     = !alu_act && !q_empty;
  assign bypass  = !alu_act && q_empty && ld_keep;
  assign push    = ld_keep && !bypass;

  always_comb begin
    port_we   = 1'b0;
    port_rd   = gpr_rd;
    port_data = gpr_rrd;
    if (alu_act) begin
      port_we   = 1'b1;
      port_rd   = alu_rd;
      port_data = alu_rrd;
    end else if (pop) begin
      port_we   = 1'b1;
      port_rd   = q_rd[rd_ptr];
      port_data = q_data[rd_ptr];
    end else if (bypass) begin
      port_we   = 1'b1;
      port_rd   = ld_rd;
      port_data = ld_data;
    end
  end

  // A new issue outranks the retiring load on the same register.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[q_rd[rd_ptr]] = 1'b0;
    else if (bypass)
      pending_next[ld_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0))
      pending_next[ld_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= ld_rd;
      q_data[wr_ptr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= '0;
      gpr_we  <= 1'b0;
      gpr_rd  <= 5'd0;
      gpr_rrd <= 32'd0;
      waw_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      pending <= pending_next;
      gpr_we  <= port_we;
      gpr_rd  <= port_rd;
      gpr_rrd <= port_data;
      if (alu_act && pending[alu_rd])
        waw_err <= 1'b1;
    end
  end

  assign stall = ((rs != 5'd0) && pending[rs]) ||
                 ((rt != 5'd0) && pending[rt]) ||
                 (ld_issue && (ld_issue_rd != 5'd0) && pending[ld_issue_rd]);

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for queue ordering, same-edge set/clear and async reset.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_we;
  logic [4:0]  alu_rd;
  logic [31:0] alu_rrd;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  rs, rt;
  logic        stall;
  logic        gpr_we;
  logic [4:0]  gpr_rd;
  logic [31:0] gpr_rrd;
  logic        waw_err;

  gpr_wb_arbiter #(.LDQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_rd(alu_rd), .alu_rrd(alu_rrd),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .rs(rs), .rt(rt), .stall(stall),
    .gpr_we(gpr_we), .gpr_rd(gpr_rd), .gpr_rrd(gpr_rrd), .waw_err(waw_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int passed = 0;
  logic [36:0] exp_q[$];

  typedef struct {
    logic        aw;  logic [4:0] ard; logic [31:0] ad;
    logic        iss; logic [4:0] ird;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldd;
    logic [4:0]  rs;  logic [4:0] rt;
    logic        e_stall; logic e_rdy;
    logic        e_we; logic [4:0] e_rd; logic [31:0] e_rrd; logic e_waw;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  function automatic vec_t mk(logic aw, logic [4:0] ard, logic [31:0] ad,
                              logic iss, logic [4:0] ird,
                              logic lv, logic [4:0] lrd, logic [31:0] ldd,
                              logic [4:0] rsv, logic [4:0] rtv,
                              logic es, logic er, logic ew, logic [4:0] erd,
                              logic [31:0] errd, logic eww);
    vec_t v;
    v.aw = aw; v.ard = ard; v.ad = ad; v.iss = iss; v.ird = ird;
    v.lv = lv; v.lrd = lrd; v.ldd = ldd; v.rs = rsv; v.rt = rtv;
    v.e_stall = es; v.e_rdy = er; v.e_we = ew; v.e_rd = erd; v.e_rrd = errd; v.e_waw = eww;
    return v;
  endfunction

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // driver tasks
  task automatic set_in(input logic aw, input logic [4:0] ard, input logic [31:0] ad,
                        input logic iss, input logic [4:0] ird,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldd,
                        input logic [4:0] rsv, input logic [4:0] rtv);
    alu_we = aw; alu_rd = ard; alu_rrd = ad;
    ld_issue = iss; ld_issue_rd = ird;
    ld_valid = lv; ld_rd = lrd; ld_data = ldd;
    rs = rsv; rt = rtv;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    set_in(v.aw, v.ard, v.ad, v.iss, v.ird, v.lv, v.lrd, v.ldd, v.rs, v.rt);
    #1;
    chk($sformatf("v%0d_stall", i), {36'd0, stall}, {36'd0, v.e_stall});
    chk($sformatf("v%0d_ld_ready", i), {36'd0, ld_ready}, {36'd0, v.e_rdy});
    tick();
    chk($sformatf("v%0d_gpr_we", i), {36'd0, gpr_we}, {36'd0, v.e_we});
    chk($sformatf("v%0d_gpr_port", i), {gpr_rd, gpr_rrd}, {v.e_rd, v.e_rrd});
    chk($sformatf("v%0d_waw_err", i), {36'd0, waw_err}, {36'd0, v.e_waw});
  endtask

  initial begin
    logic accepted;
    //              aw ard ad          iss ird lv lrd ldd          rs  rt   st rdy we rd  rrd          waw
    vecs[0]  = mk(0, 0,  0,           0, 0,  0, 0,  0,           0,  0,   0, 1, 0, 0,  32'h0,       0);
    vecs[1]  = mk(0, 0,  0,           1, 5,  0, 0,  0,           0,  0,   0, 1, 0, 0,  32'h0,       0);
    vecs[2]  = mk(0, 0,  0,           0, 0,  0, 0,  0,           5,  0,   1, 1, 0, 0,  32'h0,       0);
    vecs[3]  = mk(0, 0,  0,           0, 0,  1, 5,  32'hDEADBEEF, 5, 0,   1, 1, 1, 5,  32'hDEADBEEF, 0);
    vecs[4]  = mk(0, 0,  0,           0, 0,  0, 0,  0,           0,  5,   0, 1, 0, 5,  32'hDEADBEEF, 0);
    vecs[5]  = mk(1, 0,  32'h1234,    0, 0,  1, 4,  32'h44,      0,  0,   0, 1, 1, 4,  32'h44,      0);
    vecs[6]  = mk(0, 0,  0,           0, 0,  1, 0,  32'h99,      0,  0,   0, 1, 0, 4,  32'h44,      0);
    vecs[7]  = mk(1, 11, 32'hAAAA,    0, 0,  0, 0,  0,           0,  0,   0, 1, 1, 11, 32'hAAAA,    0);
    vecs[8]  = mk(0, 0,  0,           1, 10, 0, 0,  0,           0,  0,   0, 1, 0, 11, 32'hAAAA,    0);
    vecs[9]  = mk(1, 10, 32'h1010,    0, 0,  0, 0,  0,           10, 0,   1, 1, 1, 10, 32'h1010,    1);
    vecs[10] = mk(0, 0,  0,           0, 0,  0, 0,  0,           0,  0,   0, 1, 0, 10, 32'h1010,    1);
    vecs[11] = mk(0, 0,  0,           1, 10, 0, 0,  0,           0,  0,   1, 1, 0, 10, 32'h1010,    1);
    vecs[12] = mk(0, 0,  0,           0, 0,  1, 10, 32'h1A,      0,  10,  1, 1, 1, 10, 32'h1A,      1);
    vecs[13] = mk(0, 0,  0,           0, 0,  0, 0,  0,           10, 0,   0, 1, 0, 10, 32'h1A,      1);

    // reset
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(i);

    // ALU hogs the port while three loads arrive: two queue, the third is held off
    set_in(1, 3, 1, 0, 0, 1, 7, 32'h70, 0, 0);
    #1; chk("ord_rdy_a", {36'd0, ld_ready}, 37'd1);
    exp_q.push_back({5'd7, 32'h70});
    tick(); chk("ord_alu1", {gpr_we, gpr_rd, gpr_rrd}, {1'b1, 5'd3, 32'd1});
    set_in(1, 3, 2, 0, 0, 1, 8, 32'h80, 0, 0);
    #1; chk("ord_rdy_b", {36'd0, ld_ready}, 37'd1);
    exp_q.push_back({5'd8, 32'h80});
    tick(); chk("ord_alu2", {gpr_we, gpr_rd, gpr_rrd}, {1'b1, 5'd3, 32'd2});
    set_in(1, 3, 3, 0, 0, 1, 9, 32'h90, 0, 0);
    #1; chk("ord_rdy_full", {36'd0, ld_ready}, 37'd0);
    exp_q.push_back({5'd9, 32'h90});
    tick(); chk("ord_alu3", {gpr_we, gpr_rd, gpr_rrd}, {1'b1, 5'd3, 32'd3});
    set_in(1, 3, 4, 0, 0, 1, 9, 32'h90, 0, 0);
    #1; chk("ord_rdy_full2", {36'd0, ld_ready}, 37'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 1, 9, 32'h90, 0, 0);
    accepted = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (ld_valid && ld_ready) accepted = 1'b1;
      tick();
      if (accepted) ld_valid = 1'b0;
      if (c < 3) begin
        chk($sformatf("ord_we%0d", c), {36'd0, gpr_we}, 37'd1);
        if (exp_q.size() > 0) chk($sformatf("ord_data%0d", c), {gpr_rd, gpr_rrd}, exp_q.pop_front());
        else chk($sformatf("ord_data%0d", c), {gpr_rd, gpr_rrd}, 37'h1FFFFFFFFF);
      end else begin
        chk("ord_done", {36'd0, gpr_we}, 37'd0);
      end
    end
    chk("ord_accepted", {36'd0, accepted}, 37'd1);
    chk("ord_q_empty", 37'(exp_q.size()), 37'd0);

    // same edge: head for r6 pops while a new load to r6 issues
    set_in(0, 0, 0, 1, 6, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 3, 5, 0, 0, 1, 6, 32'h66, 6, 0);
    #1; chk("se_stall_a", {36'd0, stall}, 37'd1);
    tick(); chk("se_alu", {gpr_we, gpr_rd, gpr_rrd}, {1'b1, 5'd3, 32'd5});
    set_in(0, 0, 0, 1, 6, 0, 0, 0, 6, 0);
    #1; chk("se_stall_b", {36'd0, stall}, 37'd1);
    tick(); chk("se_pop", {gpr_we, gpr_rd, gpr_rrd}, {1'b1, 5'd6, 32'h66});
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    #1; chk("se_stall_held", {36'd0, stall}, 37'd1);
    tick();
    set_in(0, 0, 0, 0, 0, 1, 6, 32'h67, 0, 0);
    tick(); chk("se_bypass", {gpr_we, gpr_rd, gpr_rrd}, {1'b1, 5'd6, 32'h67});
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 6, 0);
    #1; chk("se_stall_clear", {36'd0, stall}, 37'd0);
    chk("waw_sticky", {36'd0, waw_err}, 37'd1);
    tick();

    // async reset with a load queued behind ALU traffic
    set_in(0, 0, 0, 1, 13, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 3, 9, 0, 0, 1, 12, 32'hC0, 13, 0);
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_we", {36'd0, gpr_we}, 37'd0);
    chk("rst_port", {gpr_rd, gpr_rrd}, 37'd0);
    chk("rst_waw", {36'd0, waw_err}, 37'd0);
    chk("rst_stall", {36'd0, stall}, 37'd0);
    idle();
    rs = 5'd13;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_rdy", {36'd0, ld_ready}, 37'd1);
    tick();
    chk("rst_dropped", {36'd0, gpr_we}, 37'd0);
    chk("rst_stall_after", {36'd0, stall}, 37'd0);
    chk("rst_waw_after", {36'd0, waw_err}, 37'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
Write-back arbiter and load scoreboard in front of the 32x32 2R/1W general purpose register file. It shares the register file's single write port between the fixed-latency ALU result path and the variable-latency load unit. Load results wait in a small queue while the port is busy. A per-register pending scoreboard raises a read-hazard stall until each outstanding load's data has reached the write port.

Parameters:
LDQ_DEPTH, 2, number of load-result queue entries (power of two, >=2)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
alu_we  in  1  ALU result valid this cycle; always accepted
alu_rd  in  5  ALU destination register
alu_rrd  in  32  ALU result data
ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
ld_issue_rd  in  5  load destination register
ld_valid  in  1  load data valid; held until accepted
ld_rd  in  5  load data destination
ld_data  in  32  load data
ld_ready  out  1  queue can accept load data (not full)
rs  in  5  decode-stage source register 1
rt  in  5  decode-stage source register 2
stall  out  1  rs, rt or ld_issue_rd is pending
gpr_we  out  1  to register file write enable, registered
gpr_rd  out  5  to register file write address, registered
gpr_rrd  out  32  to register file write data, registered
waw_err  out  1  sticky: ALU wrote a register with a load pending

Behaviour:
- Reset (rst=0, async): queue empty, scoreboard all clear, gpr_we=0, gpr_rd=0, gpr_rrd=0, waw_err=0. ld_ready=1 once rst deasserts. Reset during a queued write drops the write.
- Load handshake: transfer when ld_valid && ld_ready. ld_ready = !full, combinational from state only.
- Write-port arbitration is evaluated each cycle. Priority: ALU > queue head > incoming load.
  - alu_we=1 and alu_rd!=0: next gpr_we=1 with alu_rd and alu_rrd (latency 1).
  - Else if the queue is non-empty: pop the head to the port.
  - Else if a load transfers this cycle: bypass the queue straight to the port (latency 1).
  - Else next gpr_we=0; gpr_rd and gpr_rrd hold their values.
  - A transferring load that is not bypassed is pushed to the queue. Push and pop can occur in the same cycle; occupancy is unchanged.
- $0 handling: the register file must never see gpr_we with gpr_rd=0.
  - alu_we with alu_rd=0 is ignored; the port is free for a load that cycle.
  - A load with ld_rd=0 is accepted and discarded: never queued or written.
  - ld_issue_rd=0 sets nothing.
  - rs, rt or ld_issue_rd equal to 0 never contributes to stall.
- Scoreboard: 32 pending bits.
  - Set on ld_issue for ld_issue_rd.
  - Cleared on the clock edge that loads gpr_rd/gpr_we with a load entry for that register.
  - In the following cycle stall has dropped; the register file's same-cycle forwarding supplies the data.
  - Set and clear of the same register on the same edge: set wins, because a new load is outstanding.
- stall is combinational: pending[rs] | pending[rt] | (ld_issue & pending[ld_issue_rd]), with register 0 excluded. A second load to a pending register is thus held off.
- waw_err: set and held until reset when alu_we=1, alu_rd!=0 and pending[alu_rd]=1. The ALU write still proceeds.
- ALU-to-ALU bypass is outside this block.
- Queue pointers wrap modulo LDQ_DEPTH. Full and empty are distinguished with an occupancy count (0..LDQ_DEPTH).

Test Plan:
- Reset then idle -> gpr_we=0, stall=0, ld_ready=1, waw_err=0; asserting rst=0 mid-transfer clears all of these asynchronously.
- ld_issue rd=5, then rs=5 -> stall=1. ld_valid rd=5, data=0xDEADBEEF with no ALU traffic -> next cycle gpr_we=1, gpr_rd=5, gpr_rrd=0xDEADBEEF, and stall=0 in that same cycle.
- alu_we every cycle (rd=3, data=1,2,3...) while 3 loads arrive (rd=7,8,9) -> ld_ready=0 after 2 accepted. When alu_we stops: writes of 7 then 8 then 9 on consecutive cycles, in order, with no loss.
- alu_we rd=0 and ld_valid rd=4 in the same cycle -> load written next cycle; gpr_we never asserted with gpr_rd=0. ld_valid rd=0 -> accepted, no write.
- Same edge: head entry for rd=6 pops to the port while ld_issue rd=6 -> pending[6] stays 1 and stall holds with rs=6.
- ld_issue rd=10, then alu_we rd=10 -> waw_err=1 and ALU write occurs; waw_err stays 1 until reset.
